// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, frame size and timing helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int DATA_BITS = 8;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int timer_w(input int cpb);
    return $clog2(cpb);
  endfunction

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter for the UART receiver; half_tick marks mid-bit of the start bit, full_tick one full bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam int TW = timer_w(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr || cnt == FULL) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign half_tick = (cnt == HALF);
  assign full_tick = (cnt == FULL);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, 1 stop bit; define UART_PARITY_EN to add one even-parity bit after bit 7.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data_rx,
  output logic                 rx_en,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int IDX_W        = $clog2(DATA_BITS);

  uart_state_e          state;
  logic                 sync_p0;
  logic                 sync_p1;
  logic                 rxs;
  logic [DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]     bit_idx;
  logic                 tmr_clr;
  logic                 half_tick;
  logic                 full_tick;
  logic                 par_ok;

  // Stage p0/p1: two-flop synchroniser, reset to the idle line level
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rxd;
      sync_p1 <= sync_p0;
    end
  end

  assign rxs = sync_p1;

  // Held clear while idle so the start-bit half period begins on START entry; full_tick wraps by itself
  assign tmr_clr = (state == IDLE) || (state == START && half_tick);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (tmr_clr),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

`ifdef UART_PARITY_EN
  logic par_bit;
  assign par_ok = (par_bit == even_parity(shift));
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shift     <= '0;
      data_rx   <= '0;
      rx_en     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_en     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rxs) state <= START;
        end
        START: begin
          bit_idx <= '0;
          if (half_tick) state <= rxs ? IDLE : DATA;
        end
        DATA: begin
          if (full_tick) begin
            shift   <= {rxs, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (full_tick) begin
            par_bit <= rxs;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          // Sampled mid stop bit; returning to IDLE here leaves half a bit to catch a following start edge
          if (full_tick) begin
            state <= IDLE;
            if (!rxs) begin
              frame_err <= 1'b1;
            end else if (!par_ok) begin
`ifdef UART_PARITY_EN
              parity_err <= 1'b1;
`endif
            end else begin
              data_rx <= shift;
              rx_en   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit; parity cases are built when UART_PARITY_EN is defined.
module tb_uart_rx;

  localparam int CPB = 10;
`ifdef UART_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  localparam int LAT_MAX = PAR_ON ? 110 : 100;

  logic       clk;
  logic       rstn;
  logic       rxd;
  logic [7:0] data_rx;
  logic       rx_en;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx #(
    .CLK_FREQ (1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rxd       (rxd),
    .data_rx   (data_rx),
    .rx_en     (rx_en),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par;
    int         exp_en;
    int         exp_fe;
    int         exp_pe;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  int         nvec = 0;
  int         nfail = 0;
  int         en_cnt = 0;
  int         fe_cnt = 0;
  int         pe_cnt = 0;
  int         viol = 0;
  logic       prev_en = 1'b0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (rstn) begin
      if (rx_en) begin
        en_cnt <= en_cnt + 1;
        got_q.push_back(data_rx);
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (parity_err) pe_cnt <= pe_cnt + 1;
      if (int'(rx_en) + int'(frame_err) + int'(parity_err) > 1) viol <= viol + 1;
      if (rx_en && prev_en) viol <= viol + 1;
      prev_en <= rx_en;
    end else begin
      prev_en <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input int par);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (par >= 0) begin
      rxd = par[0];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_en, b_fe, b_pe, lat, drop, qb;
    logic [7:0] pre;
    //              data   stop  par   en fe pe  data_rx after
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 0, 1, 0, 8'hA5};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 1, 0, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 1, 0, 0, 8'hFF};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 1, 0, 0, 8'h01};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 1, 0, 0, 8'h80};
    vecs[6] = '{8'h3C, 1'b0, 1'b0, 0, 1, 0, 8'h80};

    rstn = 1'b0;
    rxd  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data_rx", 32'(data_rx), 0);
    check("reset_rx_en", 32'(rx_en), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_parity_err", 32'(parity_err), 0);
    check("reset_busy", 32'(busy), 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // first byte: latency from start edge to rx_en
    b_en = en_cnt;
    lat  = 0;
    fork
      send_byte(8'hA5, 1'b1, PAR_ON ? 0 : -1);
      begin
        for (int i = 1; i <= 150; i++) begin
          @(negedge clk);
          if (rx_en) begin
            lat = i;
            break;
          end
        end
      end
    join
    idle(25);
    check("latency_in_window", 32'(lat >= 90 && lat <= LAT_MAX), 1);
    check("latency_data", 32'(data_rx), 32'h A5);
    check("latency_pulses", 32'(en_cnt - b_en), 1);

    for (int v = 0; v < 7; v++) begin
      b_en = en_cnt;
      b_fe = fe_cnt;
      b_pe = pe_cnt;
      send_byte(vecs[v].data, vecs[v].stop, PAR_ON ? int'(vecs[v].par) : -1);
      idle(25);
      check($sformatf("vec%0d_rx_en", v), 32'(en_cnt - b_en), 32'(vecs[v].exp_en));
      check($sformatf("vec%0d_frame_err", v), 32'(fe_cnt - b_fe), 32'(vecs[v].exp_fe));
      check($sformatf("vec%0d_parity_err", v), 32'(pe_cnt - b_pe), 32'(vecs[v].exp_pe));
      check($sformatf("vec%0d_data_rx", v), 32'(data_rx), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d_busy", v), 32'(busy), 0);
    end

    // start-bit glitch of 3 clocks
    b_en = en_cnt;
    b_fe = fe_cnt;
    rxd  = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    check("glitch_busy_seen", 32'(busy), 1);
    drop = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (!busy) begin
        drop = i;
        break;
      end
    end
    check("glitch_busy_drop", 32'(drop >= 1), 1);
    idle(20);
    check("glitch_no_rx_en", 32'(en_cnt - b_en), 0);
    check("glitch_no_frame_err", 32'(fe_cnt - b_fe), 0);

    // back-to-back frames with no idle gap
    b_en = en_cnt;
    b_fe = fe_cnt;
    qb   = got_q.size();
    for (int i = 0; i < 36; i++) begin
      send_byte(8'(i), 1'b1, PAR_ON ? int'(^8'(i)) : -1);
    end
    idle(25);
    check("b2b_count", 32'(en_cnt - b_en), 36);
    check("b2b_frame_err", 32'(fe_cnt - b_fe), 0);
    if (got_q.size() >= qb + 36) begin
      for (int i = 0; i < 36; i++) begin
        check($sformatf("b2b_byte%0d", i), 32'(got_q[qb+i]), 32'(i));
      end
    end

    // reset in the middle of bit 4 of a frame (0xC3)
    b_en = en_cnt;
    b_fe = fe_cnt;
    b_pe = pe_cnt;
    pre  = 8'hC3;
    rxd  = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = pre[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = pre[4];
    repeat (CPB / 2) @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_data_rx", 32'(data_rx), 0);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_rx_en", 32'(rx_en), 0);
    check("midreset_frame_err", 32'(frame_err), 0);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle(30);
    check("midreset_no_strobes", 32'((en_cnt - b_en) + (fe_cnt - b_fe) + (pe_cnt - b_pe)), 0);
    send_byte(8'h5A, 1'b1, PAR_ON ? 0 : -1);
    idle(25);
    check("after_reset_data", 32'(data_rx), 32'h5A);
    check("after_reset_count", 32'(en_cnt - b_en), 1);

`ifdef UART_PARITY_EN
    b_en = en_cnt;
    b_pe = pe_cnt;
    send_byte(8'h07, 1'b1, 0);
    idle(25);
    check("par_bad_parity_err", 32'(pe_cnt - b_pe), 1);
    check("par_bad_no_rx_en", 32'(en_cnt - b_en), 0);
    check("par_bad_data_kept", 32'(data_rx), 32'h5A);
    send_byte(8'h07, 1'b1, 1);
    idle(25);
    check("par_good_rx_en", 32'(en_cnt - b_en), 1);
    check("par_good_data", 32'(data_rx), 32'h07);
    b_fe = fe_cnt;
    b_pe = pe_cnt;
    send_byte(8'h07, 1'b0, 0);
    idle(25);
    check("par_both_frame_err", 32'(fe_cnt - b_fe), 1);
    check("par_both_no_parity_err", 32'(pe_cnt - b_pe), 0);
`endif

    check("strobe_exclusive_single", 32'(viol), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
